// File: rtl/uart_link_pkg.sv
// Shared types and sizing helpers for the uart link scheduler.
package uart_link_pkg;

    localparam int DATA_W     = 7;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_FRAME,
        TX_START,
        TX_FRAME
    } state_e;

    function automatic int cnt_width(input int cpb, input int guard);
        return $clog2(FRAME_BITS * cpb + guard + 1);
    endfunction

endpackage

// File: rtl/uart_link_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search from pointer+1,
// pointer moves to the winner when enabled.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        gidx  = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= PW'(NREQ - 1);
        end else if (en_i && found) begin
            ptr_q <= gidx;
        end
    end

endmodule

// File: rtl/uart_link_scheduler.sv
// Half-duplex uart sequencer: receive-first scheduling with
// round-robin transmit arbitration and a post-TX guard time.
module uart_link_scheduler
    import uart_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int GUARD_CLKS   = 2 * CLKS_PER_BIT,
    parameter int NREQ         = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sin,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W-1:0]      uart_o_data,
    input  logic                   uart_success,
    output logic                   uart_rd,
    output logic                   uart_wr,
    output logic [DATA_W-1:0]      uart_i_data,
    output logic                   rx_valid,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   rx_parity_ok,
    output logic                   tx_done,
    output logic                   busy
);

    localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
    localparam int CW = cnt_width(CLKS_PER_BIT, GUARD_CLKS);
    localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] RX_LAST = CW'(FRAME_CLKS - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(FRAME_CLKS + GUARD_CLKS - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          sync_q;
    logic                prev_q;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [NREQ-1:0]     rdy_q, rdy_d;
    logic                rxv_q, rxv_d;
    logic [DATA_W-1:0]   rxd_q, rxd_d;
    logic                rxp_q, rxp_d;
    logic                done_q, done_d;
    logic [NREQ-1:0]     gnt;
    logic                arb_en;
    logic                fall;
    logic [DATA_W-1:0]   sel;

    assign fall = prev_q & ~sync_q[1];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (req_valid),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel = sel | req_data[DATA_W*i +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        tx_d    = tx_q;
        rdy_d   = '0;
        rxv_d   = 1'b0;
        rxd_d   = rxd_q;
        rxp_d   = rxp_q;
        done_d  = 1'b0;
        arb_en  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // A line fall beats any pending transmit request
                if (fall) begin
                    state_d = RX_FRAME;
                end else if (|req_valid) begin
                    arb_en  = 1'b1;
                    rdy_d   = gnt;
                    tx_d    = sel;
                    state_d = TX_START;
                end
            end
            RX_FRAME: begin
                if (cnt_q == HALF_C && sync_q[1]) begin
                    state_d = RX_IDLE;
                end else if (cnt_q == RX_LAST) begin
                    rxv_d   = 1'b1;
                    rxd_d   = uart_o_data;
                    rxp_d   = uart_success;
                    state_d = RX_IDLE;
                end
            end
            TX_START: begin
                cnt_d   = '0;
                state_d = TX_FRAME;
            end
            TX_FRAME: begin
                if (cnt_q == TX_LAST) begin
                    done_d  = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            tx_q    <= '0;
            rdy_q   <= '0;
            rxv_q   <= 1'b0;
            rxd_q   <= '0;
            rxp_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], sin};
            prev_q  <= sync_q[1];
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            rxv_q   <= rxv_d;
            rxd_q   <= rxd_d;
            rxp_q   <= rxp_d;
            done_q  <= done_d;
        end
    end

    assign uart_rd      = (state_q == RX_IDLE) || (state_q == RX_FRAME);
    assign uart_wr      = (state_q == TX_START);
    assign uart_i_data  = tx_q;
    assign req_ready    = rdy_q;
    assign rx_valid     = rxv_q;
    assign rx_data      = rxd_q;
    assign rx_parity_ok = rxp_q;
    assign tx_done      = done_q;
    assign busy         = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Scoreboard bench for uart_link_scheduler (CLKS_PER_BIT=4, GUARD=2).
module tb_uart_link_scheduler;

    localparam int CPB = 4;
    localparam int GRD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sin;
    logic [1:0]  req_valid;
    logic [13:0] req_data;
    logic [1:0]  req_ready;
    logic [6:0]  uart_o_data;
    logic        uart_success;
    logic        uart_rd;
    logic        uart_wr;
    logic [6:0]  uart_i_data;
    logic        rx_valid;
    logic [6:0]  rx_data;
    logic        rx_parity_ok;
    logic        tx_done;
    logic        busy;

    uart_link_scheduler #(
        .CLKS_PER_BIT (CPB),
        .GUARD_CLKS   (GRD),
        .NREQ         (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sin          (sin),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_o_data  (uart_o_data),
        .uart_success (uart_success),
        .uart_rd      (uart_rd),
        .uart_wr      (uart_wr),
        .uart_i_data  (uart_i_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_parity_ok (rx_parity_ok),
        .tx_done      (tx_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_cnt = 0, tx_cnt = 0, gnt_cnt = 0;
    int rx_cyc = 0, gnt_cyc = 0, fall_cyc = 0;
    int tx_len = 0;
    int rb, gb, tb;

    logic [7:0] exp_rx[$];
    logic [1:0] exp_gnt[$];
    logic [6:0] exp_tx[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d want none", nm, act);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) unexpected("rx_unexpected", rx_data);
                else begin
                    logic [7:0] e;
                    e = exp_rx.pop_front();
                    chk("rx_data", rx_data, e[6:0]);
                    chk("rx_parity", rx_parity_ok, e[7]);
                end
                rx_cnt++;
                rx_cyc = cyc;
            end
            if (req_ready != 2'b00) begin
                if (exp_gnt.size() == 0) unexpected("gnt_unexpected", req_ready);
                else chk("req_ready", req_ready, exp_gnt.pop_front());
                chk("ready_has_valid", int'(req_ready & ~req_valid), 0);
                gnt_cnt++;
                gnt_cyc = cyc;
            end
            if (uart_wr) begin
                if (exp_tx.size() == 0) unexpected("tx_unexpected", uart_i_data);
                else chk("uart_i_data", uart_i_data, exp_tx.pop_front());
                tx_len = 0;
            end else if (!uart_rd) begin
                tx_len++;
            end
            if (tx_done) begin
                chk("tx_frame_len", tx_len, 10*CPB + GRD);
                tx_cnt++;
            end
        end
    end

    task automatic send_frame(input logic [6:0] d);
        logic [9:0] f;
        f = {1'b1, ^d, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(posedge clk);
            #1 sin = f[b];
            if (b == 0) fall_cyc = cyc + 1;
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 sin = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (tx_cnt >= n) ok = 1'b1;
        end
        if (!ok) chk("tx_timeout", tx_cnt, n);
    endtask

    task automatic wait_rx(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rx_cnt >= n) ok = 1'b1;
        end
        if (!ok) chk("rx_timeout", rx_cnt, n);
    endtask

    task automatic wait_gnt(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (gnt_cnt >= n) ok = 1'b1;
        end
        if (!ok) chk("gnt_timeout", gnt_cnt, n);
    endtask

    initial begin
        reset = 1'b1;
        sin = 1'b1;
        req_valid = 2'b00;
        req_data = '0;
        uart_o_data = '0;
        uart_success = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_uart_rd", uart_rd, 1);
        chk("rst_uart_wr", uart_wr, 0);
        chk("rst_i_data", uart_i_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_par", rx_parity_ok, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // Reset in the middle of a TX frame, then alternating grants
        req_data = {7'd5, 7'd123};
        exp_gnt.push_back(2'b01);
        exp_tx.push_back(7'd123);
        req_valid = 2'b11;
        repeat (15) @(negedge clk);
        chk("mid_tx_busy", busy, 1);
        chk("mid_tx_rd", uart_rd, 0);
        reset = 1'b1;
        #1;
        chk("rst_mid_rd", uart_rd, 1);
        chk("rst_mid_wr", uart_wr, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_data", uart_i_data, 0);
        repeat (2) @(negedge clk);
        exp_gnt.push_back(2'b01);
        exp_tx.push_back(7'd123);
        exp_gnt.push_back(2'b10);
        exp_tx.push_back(7'd5);
        exp_gnt.push_back(2'b01);
        exp_tx.push_back(7'd123);
        tb = tx_cnt;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 2'b01);
        wait_tx(tb + 3);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);

        // Good frame 99
        uart_o_data = 7'd99;
        uart_success = 1'b1;
        exp_rx.push_back({1'b1, 7'd99});
        rb = rx_cnt;
        send_frame(7'd99);
        wait_rx(rb + 1);
        chk("rx_latency", rx_cyc - fall_cyc, 42);
        uart_o_data = 7'd0;
        uart_success = 1'b0;
        repeat (3) @(negedge clk);
        chk("rx_data_hold", rx_data, 99);
        chk("rx_par_hold", rx_parity_ok, 1);

        // One-cycle glitch: false start
        rb = rx_cnt;
        @(posedge clk);
        #1 sin = 1'b0;
        @(posedge clk);
        #1 sin = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy", busy, 1);
        repeat (6) @(negedge clk);
        chk("glitch_idle", busy, 0);
        repeat (50) @(negedge clk);
        chk("glitch_no_rx", rx_cnt, rb);

        // Sin fall and request in the same cycle: receive wins
        uart_o_data = 7'd42;
        uart_success = 1'b0;
        req_data[6:0] = 7'd77;
        exp_rx.push_back({1'b0, 7'd42});
        exp_gnt.push_back(2'b01);
        exp_tx.push_back(7'd77);
        rb = rx_cnt;
        gb = gnt_cnt;
        tb = tx_cnt;
        fork
            send_frame(7'd42);
            begin
                repeat (3) @(posedge clk);
                #1 req_valid = 2'b01;
            end
        join
        wait_rx(rb + 1);
        wait_gnt(gb + 1);
        req_valid = 2'b00;
        chk("gnt_after_rx", gnt_cyc - rx_cyc, 1);
        wait_tx(tb + 1);

        // Sin toggling during TX is ignored
        req_data[13:7] = 7'd33;
        exp_gnt.push_back(2'b10);
        exp_tx.push_back(7'd33);
        rb = rx_cnt;
        gb = gnt_cnt;
        tb = tx_cnt;
        req_valid = 2'b10;
        wait_gnt(gb + 1);
        req_valid = 2'b00;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1 sin = ~sin;
            repeat (2) @(posedge clk);
        end
        wait_tx(tb + 1);
        repeat (60) @(negedge clk);
        chk("tx_echo_no_rx", rx_cnt, rb);
        chk("tx_echo_idle", busy, 0);

        chk("queues_empty", exp_rx.size() + exp_gnt.size() + exp_tx.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_link_scheduler.md
Name: uart_link_scheduler

Overview:
Sequences the shared half-duplex uart (7 data bits, even parity, 1 start, 1 stop; 10-bit frame) for the game core.
- Owns the uart's rd/wr/i_data controls and watches the sin line.
- Forwards received frames with their parity status.
- Round-robin arbitrates NREQ transmit requesters (e.g. game engine, echo/ack logic).
- Never starts a transmit while a receive frame is in flight.

Parameters:
CLKS_PER_BIT, 217, clk cycles per serial bit (25 MHz, 115200 baud).
GUARD_CLKS, 2*CLKS_PER_BIT, idle cycles after a TX frame before the next action.
NREQ, 2, number of transmit requesters (2..4).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
sin  in  1  serial line, same net as uart sin; asynchronous.
req_valid  in  NREQ  per-requester transmit request.
req_data  in  7*NREQ  requester i uses bits [7i+6:7i].
req_ready  out  NREQ  one-cycle accept strobe per requester.
uart_o_data  in  7  uart received data.
uart_success  in  1  uart parity-ok flag.
uart_rd  out  1  uart receive enable.
uart_wr  out  1  uart transmit start.
uart_i_data  out  7  uart transmit data.
rx_valid  out  1  one-cycle strobe, received frame complete.
rx_data  out  7  received character, valid with rx_valid.
rx_parity_ok  out  1  parity status, valid with rx_valid.
tx_done  out  1  one-cycle strobe, TX frame plus guard elapsed.
busy  out  1  high in any state except RX_IDLE.

Behaviour:
- Reset (async) values:
  - Outputs: uart_rd=1, uart_wr=0, uart_i_data=0, req_ready=0, rx_valid=0, rx_data=0, rx_parity_ok=0, tx_done=0, busy=0.
  - Internals: state=RX_IDLE, RR pointer=NREQ-1 (requester 0 wins first), sin synchroniser=2'b11.
  - Reset mid-frame discards the latched TX character; a requester already given req_ready does not get its character resent.
- sin passes through a 2-flop synchroniser (2-cycle latency). A falling edge is sync_prev=1 and sync_cur=0.
- FRAME_CLKS = 10*CLKS_PER_BIT. The counter is wide enough for FRAME_CLKS+GUARD_CLKS.
- RX_IDLE: uart_rd=1, uart_wr=0.
  - Falling edge on sin: go to RX_FRAME and clear the counter. This has priority over any req_valid in the same cycle.
  - Otherwise, if any req_valid is set: grant the first set bit searching from pointer+1 (wrap mod NREQ). In the same cycle assert req_ready[g]=1, latch req_data[g], update pointer=g, and go to TX_START.
  - req_ready is never asserted for a requester whose req_valid is low.
  - A requester holds valid and data stable until ready. It may deassert valid before ready, which withdraws the request.
- RX_FRAME: count cycles.
  - Counter = CLKS_PER_BIT/2: if synced sin=1, it was a false start. Return to RX_IDLE with no rx_valid.
  - Counter = FRAME_CLKS-1: capture uart_o_data and uart_success into rx_data and rx_parity_ok, pulse rx_valid for 1 cycle, return to RX_IDLE.
  - Further sin edges inside the frame are ignored.
- TX_START: exactly 1 cycle. uart_rd=0, uart_wr=1, uart_i_data=latched character. Go to TX_FRAME.
- TX_FRAME: uart_rd=0, uart_wr=0, uart_i_data held. Lasts FRAME_CLKS+GUARD_CLKS cycles. Sin edges are ignored (the line echoes the local transmitter). On the last cycle, pulse tx_done; the next state is RX_IDLE.
- Back-to-back: a requester still valid after tx_done is re-arbitrated in RX_IDLE. RR guarantees no requester waits more than NREQ-1 other frames.
- rx_data and rx_parity_ok hold their value until the next rx_valid.

Decomposition:
- Package uart_link_pkg:
  - state enum {RX_IDLE, RX_FRAME, TX_START, TX_FRAME}
  - DATA_W=7, FRAME_BITS=10
  - function computing counter width from CLKS_PER_BIT and GUARD_CLKS
- Sub-module rr_arbiter (NREQ request vector, enable, grant one-hot, pointer update on enable). It is combinational search plus a registered pointer, reused by other shared resources.
- Synchroniser, counter and FSM stay in the top level.

Test Plan:
All scenarios use CLKS_PER_BIT=4, GUARD_CLKS=2, so FRAME_CLKS=40.
1. Reset asserted mid-TX_FRAME -> same-edge return to uart_rd=1, uart_wr=0, busy=0. Pointer is reset, so with both requesters valid, req_ready=2'b01 is seen 1 cycle after reset release.
2. Drive a 99 (7'h63) serial frame with correct parity on sin. Model uart_o_data=99, uart_success=1 -> rx_valid exactly once, 41-42 cycles after the sin fall (sync + 40), with rx_data=99 and rx_parity_ok=1. No req_ready during the frame.
3. A 1-cycle low glitch on sin -> false-start abort at counter 2. No rx_valid; state returns to RX_IDLE.
4. req_valid=2'b11, data0=123, data1=5, held -> grants alternate 0,1,0. Each frame has a 1-cycle uart_wr with uart_i_data=123 or 5, then 42 cycles of uart_rd=0, then tx_done.
5. Sin fall and req_valid[0] in the same cycle -> RX_FRAME is taken and no req_ready appears. After rx_valid, req_ready[0] is pulsed the following cycle.
6. Sin toggling during TX_FRAME -> no rx_valid. tx_done still arrives on schedule.
